mul_operand_dispatcher: RTL and testbench

Upstream/downstream companion of the shift-add multiplier. It buffers signed or unsigned operand pairs in a small FIFO and issues each pair to the multiplier with a one-cycle start pulse. It then waits for the multiplier's completion, captures the product, and presents it on a valid/ready output handshake. It decouples bursty producers from the multi-cycle multiplier.

---
 rtl/mul_pkg.sv | 16 +
 rtl/mul_op_fifo.sv | 57 +++++
 rtl/mul_operand_dispatcher.sv | 176 +++++++++++++++++
 tb/tb_mul_operand_dispatcher.sv | 337 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mul_pkg.sv
// Shared types for the multiplier operand dispatcher: FSM state encoding and
// operand FIFO entry sizing ({sign, a, b}).
package mul_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_HOLD  = 2'd3
    } disp_state_t;

    function automatic int entry_width(input int mul_width);
        return 1 + 2 * mul_width;
    endfunction

endpackage

// File: rtl/mul_op_fifo.sv
// Synchronous operand FIFO with full/empty flags and no bypass; pointers carry
// one extra wrap bit so full and empty are distinguishable.
module mul_op_fifo #(
    parameter int WIDTH = 9,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];

    assign empty    = (wr_ptr_q == rd_ptr_q);
    assign full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                      (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign pop_data = mem_q[rd_ptr_q[AW-1:0]];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        mem_d    = mem_q;
        if (push && !full) begin
            mem_d[wr_ptr_q[AW-1:0]] = push_data;
            wr_ptr_d                = wr_ptr_q + PTR_ONE;
        end
        if (pop && !empty) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            mem_q    <= mem_d;
        end
    end

endmodule

// File: rtl/mul_operand_dispatcher.sv
// Queues operand pairs and feeds them one at a time to the shift-add multiplier,
// returning products on a valid/ready port. MUL_DISPATCH_TIMEOUT_EN adds a WAIT watchdog.
//
// state    | meaning
// ST_IDLE  | waiting for a queued pair; pops it into the operand registers
// ST_ISSUE | mul_start high for this single cycle
// ST_WAIT  | waiting for the rising edge of mul_ready
// ST_HOLD  | product held on the output until the consumer accepts it
module mul_operand_dispatcher
    import mul_pkg::*;
#(
    parameter int MUL_WIDTH  = 4,
    parameter int FIFO_DEPTH = 4,
    parameter int TIMEOUT    = 64
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic                   in_sign,
    input  logic [MUL_WIDTH-1:0]   in_a,
    input  logic [MUL_WIDTH-1:0]   in_b,
    output logic                   mul_start,
    output logic                   mul_sign,
    output logic [MUL_WIDTH-1:0]   mul_a,
    output logic [MUL_WIDTH-1:0]   mul_b,
    input  logic                   mul_ready,
    input  logic [2*MUL_WIDTH-1:0] mul_y,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [2*MUL_WIDTH-1:0] out_data,
    output logic                   out_sign,
    output logic                   busy,
    output logic                   timeout_err
);

    localparam int EW = entry_width(MUL_WIDTH);

    disp_state_t            state_q, state_d;
    logic                   mul_sign_q, mul_sign_d;
    logic [MUL_WIDTH-1:0]   mul_a_q, mul_a_d;
    logic [MUL_WIDTH-1:0]   mul_b_q, mul_b_d;
    logic                   out_valid_q, out_valid_d;
    logic [2*MUL_WIDTH-1:0] out_data_q, out_data_d;
    logic                   out_sign_q, out_sign_d;
    logic                   ready_q;
    logic                   rise;
    logic                   expire;
    logic                   fifo_pop, fifo_full, fifo_empty;
    logic [EW-1:0]          fifo_dout;

    mul_op_fifo #(.WIDTH(EW), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (in_valid && in_ready),
        .push_data ({in_sign, in_a, in_b}),
        .pop       (fifo_pop),
        .pop_data  (fifo_dout),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    assign in_ready = !fifo_full;
    assign rise     = mul_ready && !ready_q;

`ifdef MUL_DISPATCH_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          timeout_err_q, timeout_err_d;

    // Last WAIT cycle is the one where the count would reach TIMEOUT.
    assign expire      = (cnt_q == CNT_LAST);
    assign timeout_err = timeout_err_q;

    always_comb begin
        cnt_d         = cnt_q;
        timeout_err_d = 1'b0;
        if (state_q == ST_ISSUE) begin
            cnt_d = '0;
        end else if (state_q == ST_WAIT) begin
            cnt_d         = cnt_q + CNT_ONE;
            timeout_err_d = expire && !rise;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q         <= '0;
            timeout_err_q <= 1'b0;
        end else begin
            cnt_q         <= cnt_d;
            timeout_err_q <= timeout_err_d;
        end
    end
`else
    assign expire      = 1'b0;
    assign timeout_err = 1'b0;
`endif

    always_comb begin
        state_d     = state_q;
        mul_sign_d  = mul_sign_q;
        mul_a_d     = mul_a_q;
        mul_b_d     = mul_b_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_sign_d  = out_sign_q;
        fifo_pop    = 1'b0;
        mul_start   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop                        = 1'b1;
                    {mul_sign_d, mul_a_d, mul_b_d}  = fifo_dout;
                    state_d                         = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                mul_start = 1'b1;
                state_d   = ST_WAIT;
            end
            ST_WAIT: begin
                // A completion in the final watchdog cycle still wins.
                if (rise) begin
                    out_data_d  = mul_y;
                    out_sign_d  = mul_sign_q;
                    out_valid_d = 1'b1;
                    state_d     = ST_HOLD;
                end else if (expire) begin
                    state_d = ST_IDLE;
                end
            end
            ST_HOLD: begin
                if (out_valid_q && out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            mul_sign_q  <= 1'b0;
            mul_a_q     <= '0;
            mul_b_q     <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_sign_q  <= 1'b0;
            ready_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            mul_sign_q  <= mul_sign_d;
            mul_a_q     <= mul_a_d;
            mul_b_q     <= mul_b_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_sign_q  <= out_sign_d;
            ready_q     <= mul_ready;
        end
    end

    assign mul_sign  = mul_sign_q;
    assign mul_a     = mul_a_q;
    assign mul_b     = mul_b_q;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_sign  = out_sign_q;
    assign busy      = (state_q != ST_IDLE) || !fifo_empty;

endmodule

// File: tb/tb_mul_operand_dispatcher.sv
// Directed plus randomized bench for mul_operand_dispatcher with a behavioural
// multiplier and an expected-product queue.
module tb_mul_operand_dispatcher;

    logic       clk, rst;
    logic       in_valid, in_ready, in_sign;
    logic [3:0] in_a, in_b;
    logic       mul_start, mul_sign, mul_ready;
    logic [3:0] mul_a, mul_b;
    logic [7:0] mul_y, out_data;
    logic       out_valid, out_ready, out_sign, busy, timeout_err;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int start_cnt = 0, last_start_cyc = 0, got = 0, accept_cyc = 0;
    int ov_seen = 0, to_cnt = 0, to_cyc = 0, push_cyc = 0;
    bit stall = 0, rnd_done = 0;
    bit prev_start = 0, prev_hold = 0;
    logic [7:0] prev_data;
    logic       prev_sign;
    logic [8:0] exp_q[$];

    int m_cnt = 0;
    bit m_busy = 0;
    logic [7:0] m_y;

    mul_operand_dispatcher #(.MUL_WIDTH(4), .FIFO_DEPTH(4), .TIMEOUT(16)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_sign(in_sign), .in_a(in_a), .in_b(in_b), .mul_start(mul_start),
        .mul_sign(mul_sign), .mul_a(mul_a), .mul_b(mul_b), .mul_ready(mul_ready),
        .mul_y(mul_y), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_sign(out_sign), .busy(busy),
        .timeout_err(timeout_err)
    );

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc++;

    function automatic logic [7:0] ref_mul(input logic s, input logic [3:0] a, input logic [3:0] b);
        int ia, ib, p;
        if (s) begin
            ia = int'($signed(a));
            ib = int'($signed(b));
        end else begin
            ia = int'(a);
            ib = int'(b);
        end
        p = ia * ib;
        return p[7:0];
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        chk(tag, 32'(obs), 32'(exp));
    endtask

    // Behavioural multiplier: ready drops on start, rises 5 cycles later unless stalled.
    initial begin
        mul_ready = 1'b1;
        mul_y     = 8'h00;
        forever begin
            @(negedge clk);
            if (mul_start === 1'b1) begin
                mul_ready = 1'b0;
                m_y       = ref_mul(mul_sign, mul_a, mul_b);
                m_cnt     = 5;
                m_busy    = 1;
            end else if (m_busy) begin
                if (m_cnt > 1) m_cnt--;
                else if (!stall) begin
                    mul_ready = 1'b1;
                    mul_y     = m_y;
                    m_busy    = 0;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (rst) begin
            prev_start = 0;
            prev_hold  = 0;
        end else begin
            if (mul_start) begin
                chk1("start_single_cycle", prev_start, 1'b0);
                start_cnt++;
                last_start_cyc = cyc;
            end
            prev_start = mul_start;
            if (prev_hold) begin
                chk1("hold_valid", out_valid, 1'b1);
                chk("hold_data", 32'(out_data), 32'(prev_data));
                chk1("hold_sign", out_sign, prev_sign);
            end
            if (out_valid) ov_seen++;
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    chk1("unexpected_out", out_valid, 1'b0);
                end else begin
                    chk("out_data", 32'(out_data), 32'(exp_q[0][7:0]));
                    chk1("out_sign", out_sign, exp_q[0][8]);
                    void'(exp_q.pop_front());
                end
                got++;
                accept_cyc = cyc;
            end
            if (timeout_err) begin
                to_cnt++;
                to_cyc = cyc;
            end
            prev_hold = out_valid && !out_ready;
            prev_data = out_data;
            prev_sign = out_sign;
        end
    end

    task automatic try_push(input logic s, input logic [3:0] a, input logic [3:0] b, input logic exp_rdy);
        @(negedge clk);
        in_valid = 1; in_sign = s; in_a = a; in_b = b;
        chk1("in_ready", in_ready, exp_rdy);
        if (exp_rdy) exp_q.push_back({s, ref_mul(s, a, b)});
        push_cyc = cyc;
    endtask

    task automatic push(input logic s, input logic [3:0] a, input logic [3:0] b, input bit keep);
        int n;
        @(negedge clk);
        in_valid = 1; in_sign = s; in_a = a; in_b = b;
        n = 0;
        while (!in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) chk1("push_accept", in_ready, 1'b1);
        else if (keep) exp_q.push_back({s, ref_mul(s, a, b)});
    endtask

    task automatic end_push();
        @(negedge clk);
        in_valid = 0;
    endtask

    task automatic wait_done();
        int n = 0;
        while (exp_q.size() != 0 && n < 1000) begin
            @(negedge clk);
            n++;
        end
        chk("drain", 32'(exp_q.size()), 32'd0);
    endtask

    task automatic wait_start(input int s0);
        int n = 0;
        while (start_cnt == s0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("start_seen", 32'(start_cnt != s0), 32'd1);
    endtask

    initial begin
        int s0, ov, n, t0, scyc;
        in_valid = 0; in_sign = 0; in_a = 0; in_b = 0; out_ready = 1;
        rst = 0;
        #1 rst = 1;
        #2;
        chk1("rst_mul_start", mul_start, 1'b0);
        chk1("rst_out_valid", out_valid, 1'b0);
        chk("rst_out_data", 32'(out_data), 32'd0);
        chk1("rst_busy", busy, 1'b0);
        chk1("rst_timeout_err", timeout_err, 1'b0);
        chk("rst_mul_ab", 32'({mul_sign, mul_a, mul_b}), 32'd0);
        repeat (2) @(negedge clk);
        rst = 0;
        @(negedge clk);
        chk1("rst_in_ready", in_ready, 1'b1);

        // Single unsigned op with latency and pulse-count checks
        s0 = start_cnt;
        try_push(1'b0, 4'd6, 4'd3, 1'b1);
        scyc = push_cyc;
        end_push();
        wait_done();
        chk("push_to_start", 32'(last_start_cyc - scyc), 32'd2);
        repeat (2) @(negedge clk);
        chk("start_count", 32'(start_cnt - s0), 32'd1);
        chk1("idle_busy", busy, 1'b0);
        chk1("idle_out_valid", out_valid, 1'b0);

        // Signed sequence
        try_push(1'b1, 4'hA, 4'd3, 1'b1);
        try_push(1'b1, 4'hA, 4'hD, 1'b1);
        try_push(1'b1, 4'h9, 4'hE, 1'b1);
        end_push();
        wait_done();
        repeat (3) @(negedge clk);

        // Back-to-back burst against a stalled multiplier fills the FIFO
        stall = 1;
        try_push(1'b0, 4'($urandom), 4'($urandom), 1'b1);
        try_push(1'b1, 4'($urandom), 4'($urandom), 1'b1);
        try_push(1'b0, 4'($urandom), 4'($urandom), 1'b1);
        try_push(1'b1, 4'($urandom), 4'($urandom), 1'b1);
        try_push(1'b0, 4'($urandom), 4'($urandom), 1'b1);
        try_push(1'b1, 4'($urandom), 4'($urandom), 1'b0);
        end_push();
        chk1("full_in_ready", in_ready, 1'b0);
        stall = 0;
        wait_done();
        repeat (3) @(negedge clk);

        // Output back-pressure
        @(posedge clk); #1 out_ready = 0;
        push(1'b1, 4'($urandom), 4'($urandom), 1);
        push(1'b0, 4'($urandom), 4'($urandom), 1);
        end_push();
        n = 0;
        while (!out_valid && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk1("bp_out_valid", out_valid, 1'b1);
        s0 = start_cnt;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            chk1("bp_valid_stable", out_valid, 1'b1);
            chk("bp_data", 32'(out_data), 32'(exp_q[0][7:0]));
        end
        chk("bp_no_start", 32'(start_cnt), 32'(s0));
        @(posedge clk); #1 out_ready = 1;
        wait_start(s0);
        chk("accept_to_start", 32'(last_start_cyc - accept_cyc), 32'd2);
        wait_done();

        // Reset while the multiplier is busy
        s0 = start_cnt;
        push(1'b1, 4'h5, 4'h9, 1);
        end_push();
        wait_start(s0);
        push(1'b0, 4'h7, 4'h3, 1);
        end_push();
        @(posedge clk); #2 rst = 1;
        #1;
        exp_q.delete();
        chk1("mid_rst_mul_start", mul_start, 1'b0);
        chk("mid_rst_mul_ops", 32'({mul_sign, mul_a, mul_b}), 32'd0);
        chk1("mid_rst_out_valid", out_valid, 1'b0);
        chk("mid_rst_out", 32'({out_sign, out_data}), 32'd0);
        chk1("mid_rst_busy", busy, 1'b0);
        chk1("mid_rst_timeout", timeout_err, 1'b0);
        repeat (2) @(negedge clk);
        rst = 0;
        @(negedge clk);
        chk1("post_rst_in_ready", in_ready, 1'b1);
        chk1("post_rst_busy", busy, 1'b0);
        ov = ov_seen;
        s0 = start_cnt;
        repeat (20) @(negedge clk);
        chk("post_rst_no_out", 32'(ov_seen), 32'(ov));
        chk("post_rst_no_start", 32'(start_cnt), 32'(s0));

`ifdef MUL_DISPATCH_TIMEOUT_EN
        // Watchdog drops an op that never completes
        stall = 1;
        s0 = start_cnt;
        t0 = to_cnt;
        push(1'b0, 4'd2, 4'd3, 0);
        end_push();
        wait_start(s0);
        scyc = last_start_cyc;
        push(1'b1, 4'hB, 4'd5, 1);
        end_push();
        ov = ov_seen;
        s0 = start_cnt;
        n = 0;
        while (to_cnt == t0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        stall = 0;
        chk("timeout_count", 32'(to_cnt - t0), 32'd1);
        chk("timeout_cycle", 32'(to_cyc - scyc), 32'd17);
        chk("timeout_no_out", 32'(ov_seen), 32'(ov));
        wait_start(s0);
        chk("timeout_next_issue", 32'(last_start_cyc - to_cyc), 32'd1);
        wait_done();
        chk("timeout_single_pulse", 32'(to_cnt - t0), 32'd1);
`else
        chk("no_timeout_pulses", 32'(to_cnt), 32'd0);
`endif

        // Randomized traffic with random consumer back-pressure
        fork
            begin
                for (int i = 0; i < 16; i++) begin
                    push(1'($urandom), 4'($urandom), 4'($urandom), 1);
                    if ($urandom_range(0, 2) == 0) begin
                        end_push();
                        repeat ($urandom_range(0, 6)) @(negedge clk);
                    end
                end
                end_push();
                rnd_done = 1;
            end
            begin
                while (!rnd_done) begin
                    @(posedge clk);
                    #1 out_ready = 1'($urandom);
                end
            end
        join
        @(posedge clk); #1 out_ready = 1;
        wait_done();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "global timeout");
    end

endmodule
